// File: rtl/clock_time_counter.sv
// 24-hour BCD time-of-day counter (HH:MM:SS) advanced by a gated 1 Hz strobe,
// with minute/hour set strobes and a one-cycle day-rollover pulse.
module clock_time_counter (
  input  logic       i_sysclk,
  input  logic       i_reset,
  input  logic       i_en,
  input  logic       i_1hz_stb,
  input  logic       i_set_min_stb,
  input  logic       i_set_hr_stb,
  output logic [1:0] o_hr_tens,
  output logic [3:0] o_hr_ones,
  output logic [2:0] o_min_tens,
  output logic [3:0] o_min_ones,
  output logic [2:0] o_sec_tens,
  output logic [3:0] o_sec_ones,
  output logic       o_day_stb
);

  logic [1:0] hr_tens_q, hr_tens_d;
  logic [3:0] hr_ones_q, hr_ones_d;
  logic [2:0] min_tens_q, min_tens_d;
  logic [3:0] min_ones_q, min_ones_d;
  logic [2:0] sec_tens_q, sec_tens_d;
  logic [3:0] sec_ones_q, sec_ones_d;
  logic       day_stb_q, day_stb_d;

  logic       tick;
  logic       sec_wrap, min_wrap, hr_wrap;
  logic [1:0] hr_inc_tens;
  logic [3:0] hr_inc_ones;
  logic [2:0] min_inc_tens;
  logic [3:0] min_inc_ones;
  logic [2:0] sec_inc_tens;
  logic [3:0] sec_inc_ones;

  // Incremented digit pairs are shared by the tick-carry and set paths
  always_comb begin
    tick     = i_1hz_stb & i_en & ~i_set_min_stb & ~i_set_hr_stb;
    sec_wrap = (sec_tens_q == 3'd5) && (sec_ones_q == 4'd9);
    min_wrap = (min_tens_q == 3'd5) && (min_ones_q == 4'd9);
    hr_wrap  = (hr_tens_q == 2'd2) && (hr_ones_q == 4'd3);

    sec_inc_tens = sec_tens_q;
    sec_inc_ones = sec_ones_q + 4'd1;
    if (sec_wrap) begin
      sec_inc_tens = 3'd0;
      sec_inc_ones = 4'd0;
    end else if (sec_ones_q == 4'd9) begin
      sec_inc_tens = sec_tens_q + 3'd1;
      sec_inc_ones = 4'd0;
    end

    min_inc_tens = min_tens_q;
    min_inc_ones = min_ones_q + 4'd1;
    if (min_wrap) begin
      min_inc_tens = 3'd0;
      min_inc_ones = 4'd0;
    end else if (min_ones_q == 4'd9) begin
      min_inc_tens = min_tens_q + 3'd1;
      min_inc_ones = 4'd0;
    end

    hr_inc_tens = hr_tens_q;
    hr_inc_ones = hr_ones_q + 4'd1;
    if (hr_wrap) begin
      hr_inc_tens = 2'd0;
      hr_inc_ones = 4'd0;
    end else if (hr_ones_q == 4'd9) begin
      hr_inc_tens = hr_tens_q + 2'd1;
      hr_inc_ones = 4'd0;
    end
  end

  // Next state: a tick only exists when no set strobe is present
  always_comb begin
    hr_tens_d  = hr_tens_q;
    hr_ones_d  = hr_ones_q;
    min_tens_d = min_tens_q;
    min_ones_d = min_ones_q;
    sec_tens_d = sec_tens_q;
    sec_ones_d = sec_ones_q;
    day_stb_d  = 1'b0;

    if (tick) begin
      sec_tens_d = sec_inc_tens;
      sec_ones_d = sec_inc_ones;
      if (sec_wrap) begin
        min_tens_d = min_inc_tens;
        min_ones_d = min_inc_ones;
        if (min_wrap) begin
          hr_tens_d = hr_inc_tens;
          hr_ones_d = hr_inc_ones;
          day_stb_d = hr_wrap;
        end
      end
    end else begin
      if (i_set_min_stb) begin
        min_tens_d = min_inc_tens;
        min_ones_d = min_inc_ones;
        sec_tens_d = 3'd0;
        sec_ones_d = 4'd0;
      end
      if (i_set_hr_stb) begin
        hr_tens_d = hr_inc_tens;
        hr_ones_d = hr_inc_ones;
      end
    end
  end

  always_ff @(posedge i_sysclk) begin
    if (i_reset) begin
      hr_tens_q  <= 2'd0;
      hr_ones_q  <= 4'd0;
      min_tens_q <= 3'd0;
      min_ones_q <= 4'd0;
      sec_tens_q <= 3'd0;
      sec_ones_q <= 4'd0;
      day_stb_q  <= 1'b0;
    end else begin
      hr_tens_q  <= hr_tens_d;
      hr_ones_q  <= hr_ones_d;
      min_tens_q <= min_tens_d;
      min_ones_q <= min_ones_d;
      sec_tens_q <= sec_tens_d;
      sec_ones_q <= sec_ones_d;
      day_stb_q  <= day_stb_d;
    end
  end

  assign o_hr_tens  = hr_tens_q;
  assign o_hr_ones  = hr_ones_q;
  assign o_min_tens = min_tens_q;
  assign o_min_ones = min_ones_q;
  assign o_sec_tens = sec_tens_q;
  assign o_sec_ones = sec_ones_q;
  assign o_day_stb  = day_stb_q;

endmodule

// File: tb/tb_clock_time_counter.sv
// Bench for clock_time_counter: vector table, directed corner sequences and
// random stimulus against a seconds-of-day reference model.
module tb_clock_time_counter;

  logic       i_sysclk = 1'b0;
  logic       i_reset, i_en, i_1hz_stb, i_set_min_stb, i_set_hr_stb;
  logic [1:0] o_hr_tens;
  logic [3:0] o_hr_ones;
  logic [2:0] o_min_tens;
  logic [3:0] o_min_ones;
  logic [2:0] o_sec_tens;
  logic [3:0] o_sec_ones;
  logic       o_day_stb;

  int checks = 0;
  int errors = 0;
  int m_t    = 0;   // model: seconds since midnight
  logic m_day = 1'b0;

  clock_time_counter dut (
    .i_sysclk(i_sysclk), .i_reset(i_reset), .i_en(i_en), .i_1hz_stb(i_1hz_stb),
    .i_set_min_stb(i_set_min_stb), .i_set_hr_stb(i_set_hr_stb),
    .o_hr_tens(o_hr_tens), .o_hr_ones(o_hr_ones), .o_min_tens(o_min_tens),
    .o_min_ones(o_min_ones), .o_sec_tens(o_sec_tens), .o_sec_ones(o_sec_ones),
    .o_day_stb(o_day_stb)
  );

  always #5 i_sysclk = ~i_sysclk;

  typedef struct {
    logic rst, en, hz, sm, sh;
    int   eh, em, es;
    logic ed;
  } vec_t;
  vec_t vecs[12];

  function automatic logic [19:0] pack_time(input int t);
    int h, m, s;
    h = t / 3600;
    m = (t / 60) % 60;
    s = t % 60;
    return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
  endfunction

  function automatic string fmt(input logic [19:0] v);
    return $sformatf("%0d%0d:%0d%0d:%0d%0d", v[19:18], v[17:14], v[13:11], v[10:7],
                     v[6:4], v[3:0]);
  endfunction

  function automatic logic [19:0] dut_time();
    return {o_hr_tens, o_hr_ones, o_min_tens, o_min_ones, o_sec_tens, o_sec_ones};
  endfunction

  task automatic chk_time(input string name, input int exp_t);
    checks++;
    if (dut_time() !== pack_time(exp_t)) begin
      errors++;
      $display("FAIL %s: time got %s expected %s", name, fmt(dut_time()), fmt(pack_time(exp_t)));
    end
  endtask

  task automatic chk_day(input string name, input logic exp_d);
    checks++;
    if (o_day_stb !== exp_d) begin
      errors++;
      $display("FAIL %s: o_day_stb got %b expected %b", name, o_day_stb, exp_d);
    end
  endtask

  // Reference model works on whole seconds-of-day, not digits
  task automatic model_update(input logic r, en, hz, sm, sh);
    int h, m, s;
    m_day = 1'b0;
    if (r) begin
      m_t = 0;
    end else if (sm || sh) begin
      h = m_t / 3600;
      m = (m_t / 60) % 60;
      s = m_t % 60;
      if (sm) begin
        m = (m + 1) % 60;
        s = 0;
      end
      if (sh) h = (h + 1) % 24;
      m_t = h * 3600 + m * 60 + s;
    end else if (en && hz) begin
      m_t   = (m_t + 1) % 86400;
      m_day = (m_t == 0);
    end
  endtask

  task automatic step(input logic r, en, hz, sm, sh);
    i_reset = r; i_en = en; i_1hz_stb = hz; i_set_min_stb = sm; i_set_hr_stb = sh;
    @(posedge i_sysclk);
    model_update(r, en, hz, sm, sh);
    #1;
    chk_time("model_time", m_t);
    chk_day("model_day", m_day);
  endtask

  task automatic goto_time(input int h, m, s);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < h; i++) step(0, 0, 0, 0, 1);
    for (int i = 0; i < m; i++) step(0, 0, 0, 1, 0);
    for (int i = 0; i < s; i++) step(0, 1, 1, 0, 0);
  endtask

  function automatic int hms(input int h, m, s);
    return h * 3600 + m * 60 + s;
  endfunction

  initial begin
    i_reset = 1'b1; i_en = 1'b0; i_1hz_stb = 1'b0; i_set_min_stb = 1'b0; i_set_hr_stb = 1'b0;

    //          rst en hz sm sh  h  m  s  day
    vecs[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{0, 1, 1, 0, 0, 0, 0, 1, 0};
    vecs[2]  = '{0, 1, 0, 0, 1, 1, 0, 1, 0};
    vecs[3]  = '{0, 1, 0, 1, 0, 1, 1, 0, 0};
    vecs[4]  = '{0, 0, 1, 0, 0, 1, 1, 0, 0};
    vecs[5]  = '{0, 1, 0, 1, 1, 2, 2, 0, 0};
    vecs[6]  = '{0, 1, 1, 1, 0, 2, 3, 0, 0};
    vecs[7]  = '{0, 0, 0, 0, 1, 3, 3, 0, 0};
    vecs[8]  = '{1, 1, 1, 0, 0, 0, 0, 0, 0};
    vecs[9]  = '{0, 1, 1, 0, 0, 0, 0, 1, 0};
    vecs[10] = '{0, 1, 0, 0, 0, 0, 0, 1, 0};
    vecs[11] = '{0, 1, 1, 0, 1, 1, 0, 1, 0};

    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].hz, vecs[i].sm, vecs[i].sh);
      chk_time($sformatf("vec%0d_time", i), hms(vecs[i].eh, vecs[i].em, vecs[i].es));
      chk_day($sformatf("vec%0d_day", i), vecs[i].ed);
    end

    // 59 ticks then one more: minute carry, never a day pulse
    goto_time(0, 0, 59);
    chk_time("sec59", hms(0, 0, 59));
    step(0, 1, 1, 0, 0);
    chk_time("min_carry", hms(0, 1, 0));
    chk_day("min_carry_day", 1'b0);

    // Day rollover pulses for exactly one cycle
    goto_time(23, 59, 59);
    chk_time("pre_roll", hms(23, 59, 59));
    step(0, 1, 1, 0, 0);
    chk_time("rollover", 0);
    chk_day("rollover_day", 1'b1);
    step(0, 1, 0, 0, 0);
    chk_day("rollover_day_clear", 1'b0);

    // Hour ones carry into tens
    goto_time(9, 59, 59);
    step(0, 1, 1, 0, 0);
    chk_time("hr_9_to_10", hms(10, 0, 0));
    goto_time(19, 59, 59);
    step(0, 1, 1, 0, 0);
    chk_time("hr_19_to_20", hms(20, 0, 0));

    // Set minute wraps without hour carry and clears seconds
    goto_time(9, 59, 30);
    step(0, 1, 0, 1, 0);
    chk_time("set_min_wrap", hms(9, 0, 0));
    // Set hour wraps without day pulse
    goto_time(23, 10, 5);
    step(0, 1, 0, 0, 1);
    chk_time("set_hr_wrap", hms(0, 10, 5));
    chk_day("set_hr_wrap_day", 1'b0);

    // Tick lost under set strobe; disabled ticks ignored
    goto_time(12, 34, 56);
    step(0, 1, 1, 1, 0);
    chk_time("tick_vs_setmin", hms(12, 35, 0));
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0);
    chk_time("en_low_hold", hms(12, 35, 0));

    // Reset beats a tick; both set strobes together
    goto_time(19, 59, 59);
    step(1, 1, 1, 0, 0);
    chk_time("rst_vs_tick", 0);
    chk_day("rst_vs_tick_day", 1'b0);
    goto_time(23, 59, 10);
    step(0, 1, 0, 1, 1);
    chk_time("both_sets", 0);
    chk_day("both_sets_day", 1'b0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 200) == 0, ($urandom % 4) != 0, ($urandom % 2) == 0,
           ($urandom % 16) == 0, ($urandom % 16) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_time_counter.md
CLOCK_TIME_COUNTER -- requirements
Module: clock_time_counter

Interface
REQ-001 Parameters: none; the block SHALL count a fixed 24-hour day, 00:00:00 through 23:59:59.
REQ-002 i_sysclk  input  1  system clock; all state SHALL update on its rising edge only.
REQ-003 i_reset  input  1  synchronous, active-high reset, sampled on the i_sysclk rising edge.
REQ-004 i_en  input  1  timekeeping enable; gates i_1hz_stb only.
REQ-005 i_1hz_stb  input  1  one-cycle pulse per second, driven by the upstream divider's overflow pulse.
REQ-006 i_set_min_stb  input  1  one-cycle request to advance minutes by one.
REQ-007 i_set_hr_stb  input  1  one-cycle request to advance hours by one.
REQ-008 o_hr_tens  output  2  hours tens digit, BCD, range 0-2.
REQ-009 o_hr_ones  output  4  hours ones digit, BCD, range 0-9.
REQ-010 o_min_tens  output  3  minutes tens digit, BCD, range 0-5.
REQ-011 o_min_ones  output  4  minutes ones digit, BCD, range 0-9.
REQ-012 o_sec_tens  output  3  seconds tens digit, BCD, range 0-5.
REQ-013 o_sec_ones  output  4  seconds ones digit, BCD, range 0-9.
REQ-014 o_day_stb  output  1  one-cycle pulse on the 23:59:59 -> 00:00:00 rollover.

Function
REQ-015 All outputs SHALL be driven directly from registers, with no combinational path from any input to any output.
REQ-016 Latency: an accepted strobe on cycle N SHALL be visible on the outputs at cycle N+1.
REQ-017 A tick SHALL be accepted when i_1hz_stb=1, i_en=1, i_set_min_stb=0 and i_set_hr_stb=0.
REQ-018 An accepted tick SHALL advance the seconds count by one, with ones 9 -> 0 carrying into tens.
REQ-019 Seconds 59 -> 00 SHALL carry +1 into minutes; minutes 59 -> 00 on that carry SHALL carry +1 into hours.
REQ-020 Hours SHALL wrap 23 -> 00 (not 29); hours ones SHALL wrap 9 -> 0 with carry only when hours tens is 0 or 1.
REQ-021 o_day_stb SHALL be 1 for exactly the cycle on which the outputs first show 00:00:00 after a tick-driven rollover, and 0 otherwise.
REQ-022 An i_set_min_stb pulse SHALL advance minutes by one, wrapping 59 -> 00 without carrying into hours, and SHALL clear seconds to 00.
REQ-023 An i_set_hr_stb pulse SHALL advance hours by one, wrapping 23 -> 00, SHALL NOT assert o_day_stb, and SHALL leave minutes and seconds unchanged.
REQ-024 Set strobes SHALL be honoured regardless of i_en.
REQ-025 A tick coinciding with either set strobe SHALL be discarded, not deferred; the set operation wins.
REQ-026 When i_set_min_stb and i_set_hr_stb are both asserted in one cycle, both SHALL apply: minutes+1 with no hour carry, hours+1, seconds cleared.
REQ-027 A strobe held high for K cycles SHALL be treated as K separate events, one per cycle.
REQ-028 With i_en=0 and no set strobes, all state SHALL hold and o_day_stb SHALL be 0.
REQ-029 Every digit SHALL remain within its legal BCD range at all times; no illegal BCD value is reachable from reset.

Reset
REQ-030 While i_reset=1 at a clock edge, all digits SHALL load 0 (time 00:00:00) and o_day_stb SHALL load 0.
REQ-031 Reset SHALL take priority over every other input.
REQ-032 Reset asserted in the same cycle as a tick or set strobe SHALL discard that event.
REQ-033 The first event accepted after reset SHALL be one sampled on the cycle after i_reset deasserts.

Verification
REQ-034 Reset, then 59 ticks, then 1 more tick -> outputs read 00:00:59, then 00:01:00; o_day_stb stays 0 throughout.
REQ-035 Drive the time to 23:59:59, then 1 tick -> outputs read 00:00:00 and o_day_stb=1 for exactly one cycle.
REQ-036 At 09:59:30, pulse i_set_min_stb -> outputs read 09:00:00; at 23:10:05, pulse i_set_hr_stb -> outputs read 00:10:05 with o_day_stb=0.
REQ-037 At 12:34:56, assert i_1hz_stb and i_set_min_stb in the same cycle -> outputs read 12:35:00 and the tick is lost; with i_en=0, 5 ticks -> outputs unchanged.
REQ-038 At 19:59:59, assert i_1hz_stb and i_reset together -> outputs read 00:00:00 and o_day_stb=0; also assert both set strobes together at 23:59:10 -> outputs read 00:00:00.
